// File: rtl/detect_ctrl.sv
// Link receiver-detect controller: quiet dwell, analog detect handshake with
// timeout, and a one-shot retry that confirms a partial lane mask.
module detect_ctrl #(
  parameter int WIDTH            = 4,
  parameter int QUIET_CYCLES     = 16,
  parameter int ACTIVE_TO_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] eidle_exit,
  output logic             rx_det_req,
  input  logic             rx_det_ack,
  input  logic [WIDTH-1:0] rx_det_vld,
  output logic             det_done,
  output logic [WIDTH-1:0] det_lanes,
  output logic             det_timeout,
  output logic [2:0]       state,
  output logic [7:0]       attempt_cnt
);

  localparam int DW = $clog2(QUIET_CYCLES + 1);
  localparam int TW = $clog2(ACTIVE_TO_CYCLES + 1);
  localparam logic [DW-1:0]    DWELL_LAST = DW'(QUIET_CYCLES - 1);
  localparam logic [TW-1:0]    TO_LAST    = TW'(ACTIVE_TO_CYCLES - 1);
  localparam logic [TW-1:0]    TO_MAX     = {TW{1'b1}};
  localparam logic [WIDTH-1:0] ALL_ONES   = {WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_DISABLED    = 3'd0,
    ST_QUIET       = 3'd1,
    ST_ACTIVE_REQ  = 3'd2,
    ST_ACTIVE_WAIT = 3'd3,
    ST_RETRY_WAIT  = 3'd4,
    ST_DONE        = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [DW-1:0]    dwell_r, dwell_s;
  logic [TW-1:0]    to_r, to_s, to_inc_s;
  logic             retry_r, retry_s;
  logic [WIDTH-1:0] mask_r, mask_s;
  logic [WIDTH-1:0] lanes_r, lanes_s;
  logic             done_r, done_s;
  logic             timeout_r, timeout_s;
  logic             req_r, req_s;
  logic [7:0]       attempt_r, attempt_s;

  // Next-state, counter and pulse decode; en=0 overrides every state.
  always_comb begin
    state_s   = state_r;
    dwell_s   = {DW{1'b0}};
    to_s      = {TW{1'b0}};
    retry_s   = retry_r;
    mask_s    = mask_r;
    lanes_s   = lanes_r;
    done_s    = 1'b0;
    timeout_s = 1'b0;
    // Saturate so a late ack past the limit cannot wrap the counter back to zero.
    if (to_r == TO_MAX) begin
      to_inc_s = to_r;
    end else begin
      to_inc_s = to_r + TW'(1'b1);
    end

    if (!en) begin
      state_s = ST_DISABLED;
      retry_s = 1'b0;
      mask_s  = {WIDTH{1'b0}};
      lanes_s = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_DISABLED: begin
          state_s = ST_QUIET;
        end
        ST_QUIET: begin
          if ((dwell_r == DWELL_LAST) ||
              ((dwell_r != {DW{1'b0}}) && (|eidle_exit))) begin
            state_s = ST_ACTIVE_REQ;
          end else begin
            dwell_s = dwell_r + DW'(1'b1);
          end
        end
        ST_ACTIVE_REQ: begin
          if (rx_det_ack) begin
            state_s = ST_ACTIVE_WAIT;
            to_s    = to_inc_s;
          end else if (to_r >= TO_LAST) begin
            state_s   = ST_QUIET;
            timeout_s = 1'b1;
            retry_s   = 1'b0;
          end else begin
            to_s = to_inc_s;
          end
        end
        ST_ACTIVE_WAIT: begin
          if (!rx_det_ack) begin
            if (!retry_r) begin
              if (rx_det_vld == ALL_ONES) begin
                state_s = ST_DONE;
                lanes_s = rx_det_vld;
                done_s  = 1'b1;
              end else if (rx_det_vld == {WIDTH{1'b0}}) begin
                state_s = ST_QUIET;
              end else begin
                state_s = ST_RETRY_WAIT;
                mask_s  = rx_det_vld;
                retry_s = 1'b1;
              end
            end else begin
              // Second look: accept only a repeat of the stored mask or a full link.
              if ((rx_det_vld == mask_r) || (rx_det_vld == ALL_ONES)) begin
                state_s = ST_DONE;
                lanes_s = rx_det_vld;
                done_s  = 1'b1;
              end else begin
                state_s = ST_QUIET;
              end
              retry_s = 1'b0;
            end
          end else if (to_r >= TO_LAST) begin
            state_s   = ST_QUIET;
            timeout_s = 1'b1;
            retry_s   = 1'b0;
          end else begin
            to_s = to_inc_s;
          end
        end
        ST_RETRY_WAIT: begin
          if (dwell_r == DWELL_LAST) begin
            state_s = ST_ACTIVE_REQ;
          end else begin
            dwell_s = dwell_r + DW'(1'b1);
          end
        end
        ST_DONE: begin
          state_s = ST_DONE;
        end
        default: begin
          state_s = ST_DISABLED;
          retry_s = 1'b0;
          lanes_s = {WIDTH{1'b0}};
        end
      endcase
    end

    req_s = (state_s == ST_ACTIVE_REQ);
    if ((state_s == ST_ACTIVE_REQ) && (state_r != ST_ACTIVE_REQ) &&
        (attempt_r != 8'hFF)) begin
      attempt_s = attempt_r + 8'd1;
    end else begin
      attempt_s = attempt_r;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_DISABLED;
      dwell_r   <= {DW{1'b0}};
      to_r      <= {TW{1'b0}};
      retry_r   <= 1'b0;
      mask_r    <= {WIDTH{1'b0}};
      lanes_r   <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      req_r     <= 1'b0;
      attempt_r <= 8'd0;
    end else begin
      state_r   <= state_s;
      dwell_r   <= dwell_s;
      to_r      <= to_s;
      retry_r   <= retry_s;
      mask_r    <= mask_s;
      lanes_r   <= lanes_s;
      done_r    <= done_s;
      timeout_r <= timeout_s;
      req_r     <= req_s;
      attempt_r <= attempt_s;
    end
  end

  assign state       = state_r;
  assign rx_det_req  = req_r;
  assign det_done    = done_r;
  assign det_timeout = timeout_r;
  assign det_lanes   = lanes_r;
  assign attempt_cnt = attempt_r;

endmodule
